// File: rtl/stepper_pulse_generator_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stepper_pkg
// Description : Register map, control bit positions and FSM state encoding
//               shared by the stepper pulse generator and its bench.
// Revision    : 1.0 - initial release
// ============================================================================
package stepper_pkg;

  // Word addresses of the register map
  localparam logic [2:0] ADDR_STATUS    = 3'd0;
  localparam logic [2:0] ADDR_CONTROL   = 3'd1;
  localparam logic [2:0] ADDR_PERIOD_LO = 3'd2;
  localparam logic [2:0] ADDR_PERIOD_HI = 3'd3;
  localparam logic [2:0] ADDR_STEPS     = 3'd4;
  localparam logic [2:0] ADDR_PULSE     = 3'd5;
  localparam logic [2:0] ADDR_REMAINING = 3'd6;
  localparam logic [2:0] ADDR_POSITION  = 3'd7;

  // Control register bit positions
  localparam int CTRL_IRQ_EN = 0;
  localparam int CTRL_DIR    = 1;
  localparam int CTRL_START  = 2;
  localparam int CTRL_STOP   = 3;
  localparam int CTRL_DRV_EN = 4;

  // Move sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_HIGH  = 2'd2,
    ST_LOW   = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/stepper_pulse_generator_if.sv
`default_nettype none
// ============================================================================
// Module      : stepper_pulse_generator_if
// Description : Avalon-MM slave bus bundle (16-bit data, 3-bit word address,
//               registered readdata).
// Revision    : 1.0 - initial release
// ============================================================================
interface stepper_pulse_generator_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface
`default_nettype wire

// File: rtl/stepper_pulse_generator_phase_counter.sv
`default_nettype none
// ============================================================================
// Module      : stepper_phase_counter
// Description : Loadable down-counter that stops at zero; tc_o flags the
//               last cycle of a phase. Times SETUP, HIGH and LOW.
// Revision    : 1.0 - initial release
// ============================================================================
module stepper_phase_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] value_i,
  output logic             tc_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: load wins, otherwise count down and hold at zero
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = value_i;
    end else if (count_q != '0) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  // Count register
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/stepper_pulse_generator.sv
`default_nettype none
// ============================================================================
// Module      : stepper_pulse_generator
// Description : Avalon-MM stepper peripheral. Turns a programmed move (step
//               count, period, pulse width, direction) into STEP/DIR pulses
//               and raises irq once per finished move.
// Revision    : 1.0 - initial release
// ============================================================================
module stepper_pulse_generator
  import stepper_pkg::*;
#(
  parameter logic [31:0] DEFAULT_PERIOD = 32'd50000,
  parameter logic [15:0] DEFAULT_PULSE  = 16'd100,
  parameter logic [7:0]  DIR_SETUP      = 8'd50
) (
  input  logic                      clk,
  input  logic                      reset,
  stepper_pulse_generator_if.slave  bus,
  output logic                      irq,
  output logic                      step,
  output logic                      dir,
  output logic                      enable_n
);

  // Programmable registers
  logic [31:0] period_q;
  logic [15:0] pulse_q;
  logic [15:0] step_count_q;
  logic [15:0] remaining_q;
  logic [15:0] position_q;
  logic        irq_en_q;
  logic        dir_req_q;
  logic        drv_en_q;
  logic        done_q;
  logic        aborted_q;
  logic        dir_q;
  logic [15:0] readdata_q;

  // Sequencer
  state_e      state_q;
  state_e      state_d;
  logic        step_q;
  logic        step_d;

  // Bus decode
  logic        wr;
  logic        wr_status;
  logic        wr_ctrl;
  logic        start_stb;
  logic        stop_stb;
  logic        busy;

  // Phase timing
  logic [31:0] high_time;
  logic [31:0] low_time;
  logic        cnt_load;
  logic [31:0] cnt_value;
  logic        cnt_tc;
  logic        enter_high;
  logic        start_move;
  logic        set_done;
  logic        set_abort;

  assign wr        = bus.chipselect && !bus.write_n;
  assign wr_status = wr && (bus.address == ADDR_STATUS);
  assign wr_ctrl   = wr && (bus.address == ADDR_CONTROL);
  // Stop takes priority, so a combined start+stop write never launches a move
  assign stop_stb  = wr_ctrl && bus.writedata[CTRL_STOP];
  assign start_stb = wr_ctrl && bus.writedata[CTRL_START] && !bus.writedata[CTRL_STOP];
  assign busy      = (state_q != ST_IDLE);

  // A zero pulse width still yields a one-cycle pulse; the low phase never
  // collapses below one cycle even when period does not exceed the pulse.
  assign high_time = (pulse_q == 16'd0) ? 32'd1 : {16'd0, pulse_q};
  assign low_time  = (period_q > high_time) ? (period_q - high_time) : 32'd1;

  stepper_phase_counter #(
    .WIDTH (32)
  ) u_phase_counter (
    .clk     (clk),
    .reset   (reset),
    .load_i  (cnt_load),
    .value_i (cnt_value),
    .tc_o    (cnt_tc)
  );

  // Next-state and phase-counter control for the move sequencer
  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    cnt_load   = 1'b0;
    cnt_value  = 32'd0;
    enter_high = 1'b0;
    start_move = 1'b0;
    set_done   = 1'b0;
    set_abort  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_stb) begin
          start_move = 1'b1;
          if (step_count_q == 16'd0) begin
            set_done = 1'b1;
          end else begin
            cnt_load  = 1'b1;
            cnt_value = {24'd0, DIR_SETUP};
            state_d   = ST_SETUP;
          end
        end
      end
      ST_SETUP: begin
        if (cnt_tc) begin
          enter_high = 1'b1;
        end
      end
      ST_HIGH: begin
        if (cnt_tc) begin
          state_d   = ST_LOW;
          step_d    = 1'b0;
          cnt_load  = 1'b1;
          cnt_value = low_time - 32'd1;
        end
      end
      ST_LOW: begin
        if (cnt_tc) begin
          if (remaining_q == 16'd0) begin
            state_d  = ST_IDLE;
            set_done = 1'b1;
          end else begin
            enter_high = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        step_d  = 1'b0;
      end
    endcase

    if (enter_high) begin
      state_d   = ST_HIGH;
      step_d    = 1'b1;
      cnt_load  = 1'b1;
      cnt_value = high_time - 32'd1;
    end

    // Abort overrides whatever phase transition was pending this cycle
    if (stop_stb && busy) begin
      state_d    = ST_IDLE;
      step_d     = 1'b0;
      enter_high = 1'b0;
      cnt_load   = 1'b0;
      set_done   = 1'b1;
      set_abort  = 1'b1;
    end
  end

  // Sequencer state and STEP output register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
    end
  end

  // Register file, move counters and completion flags
  always_ff @(posedge clk) begin
    if (reset) begin
      period_q     <= DEFAULT_PERIOD;
      pulse_q      <= DEFAULT_PULSE;
      step_count_q <= 16'd0;
      remaining_q  <= 16'd0;
      position_q   <= 16'd0;
      irq_en_q     <= 1'b0;
      dir_req_q    <= 1'b0;
      drv_en_q     <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      dir_q        <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        irq_en_q  <= bus.writedata[CTRL_IRQ_EN];
        dir_req_q <= bus.writedata[CTRL_DIR];
        drv_en_q  <= bus.writedata[CTRL_DRV_EN];
      end
      if (wr && bus.address == ADDR_PERIOD_LO) period_q[15:0]  <= bus.writedata;
      if (wr && bus.address == ADDR_PERIOD_HI) period_q[31:16] <= bus.writedata;
      if (wr && bus.address == ADDR_STEPS)     step_count_q    <= bus.writedata;
      if (wr && bus.address == ADDR_PULSE)     pulse_q         <= bus.writedata;

      // DIR follows the direction bit carried by the start write itself
      if (start_move) begin
        dir_q       <= bus.writedata[CTRL_DIR];
        remaining_q <= step_count_q;
      end else if (enter_high) begin
        remaining_q <= remaining_q - 16'd1;
      end

      if (enter_high) begin
        position_q <= dir_q ? (position_q + 16'd1) : (position_q - 16'd1);
      end else if (wr && bus.address == ADDR_POSITION && !busy) begin
        position_q <= bus.writedata;
      end

      // Setting a flag beats a same-cycle status-write clear
      if (set_done) begin
        done_q <= 1'b1;
      end else if (wr_status) begin
        done_q <= 1'b0;
      end
      if (set_abort) begin
        aborted_q <= 1'b1;
      end else if (wr_status) begin
        aborted_q <= 1'b0;
      end
    end
  end

  // Registered read mux, reflects register state before this edge
  always_ff @(posedge clk) begin
    if (reset) begin
      readdata_q <= 16'd0;
    end else begin
      case (bus.address)
        ADDR_STATUS:    readdata_q <= {13'd0, aborted_q, busy, done_q};
        ADDR_CONTROL:   readdata_q <= {11'd0, drv_en_q, 2'b00, dir_req_q, irq_en_q};
        ADDR_PERIOD_LO: readdata_q <= period_q[15:0];
        ADDR_PERIOD_HI: readdata_q <= period_q[31:16];
        ADDR_STEPS:     readdata_q <= step_count_q;
        ADDR_PULSE:     readdata_q <= pulse_q;
        ADDR_REMAINING: readdata_q <= remaining_q;
        ADDR_POSITION:  readdata_q <= position_q;
        default:        readdata_q <= 16'd0;
      endcase
    end
  end

  assign bus.readdata = readdata_q;
  assign step         = step_q;
  assign dir          = dir_q;
  assign enable_n     = ~drv_en_q;
  assign irq          = done_q & irq_en_q;

endmodule
`default_nettype wire

// File: tb/tb_stepper_pulse_generator.sv
`default_nettype none
// ============================================================================
// Module      : tb_stepper_pulse_generator
// Description : Self-checking bench for stepper_pulse_generator; expected
//               pulse timing and register values come from move arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stepper_pulse_generator;
  import stepper_pkg::*;

  localparam logic [7:0] DS = 8'd2;

  logic clk = 1'b0;
  logic reset;
  logic irq, step, dir, enable_n;

  stepper_pulse_generator_if bus ();

  stepper_pulse_generator #(
    .DIR_SETUP (DS)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .irq      (irq),
    .step     (step),
    .dir      (dir),
    .enable_n (enable_n)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Edge log of STEP, stamped with the index of the clock edge that moved it
  int   rise_q[$];
  int   fall_q[$];
  logic step_prev = 1'b0;
  always @(posedge clk) begin
    #1;
    if (step && !step_prev) rise_q.push_back(cyc);
    if (!step && step_prev) fall_q.push_back(cyc);
    step_prev = step;
  end

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] m_pos = 16'd0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [15:0] d, output int edge_no);
    @(negedge clk);
    bus.address    = a;
    bus.writedata  = d;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    @(negedge clk);
    edge_no        = cyc;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [15:0] d);
    @(negedge clk);
    bus.address    = a;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b1;
    @(negedge clk);
    d              = bus.readdata;
    bus.chipselect = 1'b0;
  endtask

  function automatic logic [15:0] ctrl_word(input bit drv, input bit stop, input bit start,
                                            input bit d, input bit ie);
    logic [15:0] w;
    w = 16'd0;
    w[CTRL_DRV_EN] = drv;
    w[CTRL_STOP]   = stop;
    w[CTRL_START]  = start;
    w[CTRL_DIR]    = d;
    w[CTRL_IRQ_EN] = ie;
    return w;
  endfunction

  // Program and run one complete move, checking pulse timing and final registers
  task automatic run_move(input int per, input int pw, input int cnt, input bit d, input bit ie);
    int          s, e, h, l, tdone, nr, nf;
    logic [15:0] rd;
    logic [31:0] per_v;
    per_v = per;
    bus_write(ADDR_PERIOD_LO, per_v[15:0], e);
    bus_write(ADDR_PERIOD_HI, per_v[31:16], e);
    bus_write(ADDR_PULSE, 16'(pw), e);
    bus_write(ADDR_STEPS, 16'(cnt), e);
    rise_q.delete();
    fall_q.delete();
    bus_write(ADDR_CONTROL, ctrl_word(1'b1, 1'b0, 1'b1, d, ie), s);
    h = (pw == 0) ? 1 : pw;
    l = (per > h) ? per - h : 1;
    if (cnt == 0) begin
      chk("zero_irq", 32'(irq), 32'(ie));
    end else begin
      chk("dir_latched", 32'(dir), 32'(d));
      tdone = s + int'(DS) + 1 + cnt * (h + l);
      while (cyc < tdone - 1) @(negedge clk);
      chk("irq_before_done", 32'(irq), 32'd0);
      @(negedge clk);
      chk("irq_at_done", 32'(irq), 32'(ie));
      nr = rise_q.size();
      nf = fall_q.size();
      chk("rise_count", 32'(nr), 32'(cnt));
      chk("fall_count", 32'(nf), 32'(cnt));
      for (int i = 0; i < cnt && i < nr && i < nf; i++) begin
        chk($sformatf("rise%0d", i), 32'(rise_q[i]), 32'(s + int'(DS) + 1 + i * (h + l)));
        chk($sformatf("fall%0d", i), 32'(fall_q[i]), 32'(s + int'(DS) + 1 + i * (h + l) + h));
      end
    end
    m_pos = d ? (m_pos + 16'(cnt)) : (m_pos - 16'(cnt));
    bus_read(ADDR_STATUS, rd);
    chk("status_done", 32'(rd), 32'd1);
    bus_read(ADDR_REMAINING, rd);
    chk("remaining_end", 32'(rd), 32'd0);
    bus_read(ADDR_POSITION, rd);
    chk("position_end", 32'(rd), 32'(m_pos));
    chk("enable_n_on", 32'(enable_n), 32'd0);
    if (cnt == 0) chk("zero_no_pulse", 32'(rise_q.size()), 32'd0);
    bus_write(ADDR_STATUS, 16'd0, e);
    chk("irq_cleared", 32'(irq), 32'd0);
    bus_read(ADDR_STATUS, rd);
    chk("status_cleared", 32'(rd), 32'd0);
  endtask

  initial begin
    int          e;
    logic [15:0] rd;
    logic [15:0] exp_rst [8];

    reset          = 1'b1;
    bus.address    = 3'd0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = 16'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state
    chk("rst_step", 32'(step), 32'd0);
    chk("rst_enable_n", 32'(enable_n), 32'd1);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_dir", 32'(dir), 32'd0);
    exp_rst = '{16'd0, 16'd0, 16'hC350, 16'd0, 16'd0, 16'd100, 16'd0, 16'd0};
    for (int a = 0; a < 8; a++) begin
      bus_read(3'(a), rd);
      chk($sformatf("rst_reg%0d", a), 32'(rd), 32'(exp_rst[a]));
    end

    // Directed moves: forward, reverse from zero, empty move, long pulse
    run_move(10, 3, 4, 1'b1, 1'b1);
    bus_write(ADDR_POSITION, 16'd0, e);
    m_pos = 16'd0;
    run_move(10, 3, 4, 1'b0, 1'b1);
    chk("reverse_pos", 32'(m_pos), 32'h0000FFFC);
    run_move(10, 3, 0, 1'b1, 1'b1);
    run_move(10, 20, 2, 1'b1, 1'b0);

    // Randomized moves from a random starting position
    for (int k = 0; k < 6; k++) begin
      logic [15:0] p0;
      p0 = 16'($urandom);
      bus_write(ADDR_POSITION, p0, e);
      m_pos = p0;
      run_move(int'($urandom_range(1, 20)), int'($urandom_range(0, 12)),
               int'($urandom_range(0, 5)), 1'($urandom), 1'($urandom));
    end

    // Abort after five steps; position writes while busy are ignored
    bus_write(ADDR_PERIOD_LO, 16'd10, e);
    bus_write(ADDR_PERIOD_HI, 16'd0, e);
    bus_write(ADDR_PULSE, 16'd3, e);
    bus_write(ADDR_STEPS, 16'd100, e);
    rise_q.delete();
    fall_q.delete();
    bus_write(ADDR_CONTROL, ctrl_word(1'b1, 1'b0, 1'b1, 1'b1, 1'b0), e);
    bus_write(ADDR_POSITION, 16'h1234, e);
    for (int i = 0; i < 300 && rise_q.size() < 5; i++) @(negedge clk);
    chk("stop_wait_5_rises", 32'(rise_q.size() >= 5), 32'd1);
    bus_write(ADDR_CONTROL, ctrl_word(1'b1, 1'b1, 1'b0, 1'b1, 1'b0), e);
    chk("stop_step_low", 32'(step), 32'd0);
    bus_read(ADDR_STATUS, rd);
    chk("stop_status", 32'(rd), 32'd5);
    bus_read(ADDR_REMAINING, rd);
    chk("stop_remaining", 32'(rd), 32'd95);
    m_pos = m_pos + 16'd5;
    bus_read(ADDR_POSITION, rd);
    chk("stop_position", 32'(rd), 32'(m_pos));
    repeat (30) @(negedge clk);
    chk("stop_no_more_rises", 32'(rise_q.size()), 32'd5);
    bus_write(ADDR_STATUS, 16'd0, e);

    // Start and stop together: nothing happens
    bus_write(ADDR_CONTROL, ctrl_word(1'b1, 1'b1, 1'b1, 1'b1, 1'b0), e);
    bus_read(ADDR_STATUS, rd);
    chk("startstop_status", 32'(rd), 32'd0);
    repeat (20) @(negedge clk);
    chk("startstop_no_rise", 32'(rise_q.size()), 32'd5);

    // Reset in the middle of a 20-cycle HIGH phase
    bus_write(ADDR_PULSE, 16'd20, e);
    bus_write(ADDR_STEPS, 16'd2, e);
    rise_q.delete();
    bus_write(ADDR_CONTROL, ctrl_word(1'b1, 1'b0, 1'b1, 1'b1, 1'b1), e);
    for (int i = 0; i < 100 && rise_q.size() < 1; i++) @(negedge clk);
    chk("midhigh_rise_seen", 32'(rise_q.size()), 32'd1);
    repeat (3) @(negedge clk);
    chk("midhigh_step_high", 32'(step), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_step", 32'(step), 32'd0);
    chk("midrst_enable_n", 32'(enable_n), 32'd1);
    chk("midrst_dir", 32'(dir), 32'd0);
    reset = 1'b0;
    bus_read(ADDR_STATUS, rd);
    chk("midrst_status", 32'(rd), 32'd0);
    bus_read(ADDR_POSITION, rd);
    chk("midrst_position", 32'(rd), 32'd0);
    bus_read(ADDR_PERIOD_LO, rd);
    chk("midrst_period_lo", 32'(rd), 32'h0000C350);
    bus_read(ADDR_PULSE, rd);
    chk("midrst_pulse", 32'(rd), 32'd100);
    repeat (30) @(negedge clk);
    chk("midrst_no_rise", 32'(rise_q.size()), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
